mem_access_unit: RTL and testbench

//  Memory stage fed by the ex stage. Takes one ALU result plus a load/store op per transaction.

---
 rtl/mem_access_unit.sv | 199 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory stage: byte-serial little-endian loads/stores over an 8-bit RAM port, one transaction at a time.
// Optional macro MEM_MISALIGN_TRAP_EN: misaligned H/W ops skip the RAM and pulse misalign_o with out_valid.
module mem_access_unit #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   mem_op,
  input  logic [XLEN-1:0]   alu_res,
  input  logic [XLEN-1:0]   st_data,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic              rd_enable,
  output logic [XLEN-1:0]   ram_addr,
  output logic              ram_rw_en,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic              out_valid,
  output logic [XLEN-1:0]   rd_data_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic              rd_enable_o
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic              misalign_o
`endif
);

  localparam logic [OP_W-1:0] OP_NONE = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LB   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LH   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_LBU  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_LHU  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SB   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SH   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(8);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

  state_t            state_reg;
  logic [OP_W-1:0]   op_reg;
  logic [XLEN-1:0]   addr_reg;
  logic [XLEN-1:0]   st_data_reg;
  logic [REG_AW-1:0] rd_addr_reg;
  logic              rd_en_reg;
  logic              store_reg;
  logic [2:0]        n_reg;
  logic [1:0]        k_reg;
  logic [1:0]        cap_idx_reg;
  logic              pend_reg;
  logic [XLEN-1:0]   asm_reg;
`ifdef MEM_MISALIGN_TRAP_EN
  logic              mis_reg;
`endif

  logic [OP_W-1:0]   op_dec;
  logic [2:0]        n_dec;
  logic              st_dec;
  logic              trap_dec;
  logic [XLEN-1:0]   asm_next;
  logic [XLEN-1:0]   res_data;
  logic              res_en;
  logic              last_byte;

  always_comb begin
    op_dec   = mem_op;
    n_dec    = 3'd0;
    st_dec   = (mem_op == OP_SB) || (mem_op == OP_SH) || (mem_op == OP_SW);
    trap_dec = 1'b0;
    case (mem_op)
      OP_LB, OP_LBU, OP_SB: n_dec = 3'd1;
      OP_LH, OP_LHU, OP_SH: n_dec = 3'd2;
      OP_LW, OP_SW:         n_dec = 3'd4;
      default:              op_dec = OP_NONE;
    endcase
`ifdef MEM_MISALIGN_TRAP_EN
    trap_dec = ((n_dec == 3'd2) && alu_res[0]) || ((n_dec == 3'd4) && (alu_res[1:0] != 2'b00));
`endif
  end

  // The last load byte arrives in the RESP cycle itself, so the result is built from the merged view.
  always_comb begin
    asm_next = asm_reg;
    if (pend_reg) asm_next[8*cap_idx_reg +: 8] = ram_din;
    res_data = '0;
    res_en   = rd_en_reg;
    case (op_reg)
      OP_LB:               res_data = {{(XLEN-8){asm_next[7]}}, asm_next[7:0]};
      OP_LH:               res_data = {{(XLEN-16){asm_next[15]}}, asm_next[15:0]};
      OP_LW:               res_data = asm_next;
      OP_LBU:              res_data = XLEN'(asm_next[7:0]);
      OP_LHU:              res_data = XLEN'(asm_next[15:0]);
      OP_SB, OP_SH, OP_SW: res_en   = 1'b0;
      default:             res_data = addr_reg;
    endcase
`ifdef MEM_MISALIGN_TRAP_EN
    if (mis_reg) begin
      res_data = '0;
      res_en   = 1'b0;
    end
`endif
  end

  assign last_byte = ({1'b0, k_reg} == (n_reg - 3'd1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      op_reg      <= OP_NONE;
      addr_reg    <= '0;
      st_data_reg <= '0;
      rd_addr_reg <= '0;
      rd_en_reg   <= 1'b0;
      store_reg   <= 1'b0;
      n_reg       <= 3'd0;
      k_reg       <= 2'd0;
      cap_idx_reg <= 2'd0;
      pend_reg    <= 1'b0;
      asm_reg     <= '0;
      in_ready    <= 1'b1;
      ram_addr    <= '0;
      ram_rw_en   <= 1'b0;
      ram_wr      <= 1'b0;
      ram_dout    <= 8'h00;
      out_valid   <= 1'b0;
      rd_data_o   <= '0;
      rd_addr_o   <= '0;
      rd_enable_o <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_reg     <= 1'b0;
      misalign_o  <= 1'b0;
`endif
    end else begin
      // A read strobe visible now means its byte is on ram_din during the next cycle.
      pend_reg <= ram_rw_en & ~ram_wr;
      if (pend_reg) begin
        asm_reg     <= asm_next;
        cap_idx_reg <= cap_idx_reg + 2'd1;
      end
      case (state_reg)
        IDLE: begin
          out_valid <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
          misalign_o <= 1'b0;
`endif
          if (in_valid && in_ready) begin
            op_reg      <= op_dec;
            addr_reg    <= alu_res;
            st_data_reg <= st_data;
            rd_addr_reg <= rd_addr;
            rd_en_reg   <= rd_enable;
            store_reg   <= st_dec;
            n_reg       <= n_dec;
            k_reg       <= 2'd0;
            cap_idx_reg <= 2'd0;
            asm_reg     <= '0;
            in_ready    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_reg     <= trap_dec;
`endif
            state_reg   <= ((n_dec == 3'd0) || trap_dec) ? RESP : ISSUE;
          end
        end
        ISSUE: begin
          ram_rw_en <= 1'b1;
          ram_wr    <= store_reg;
          ram_addr  <= addr_reg + XLEN'(k_reg);
          ram_dout  <= store_reg ? st_data_reg[8*k_reg +: 8] : 8'h00;
          k_reg     <= k_reg + 2'd1;
          if (last_byte) state_reg <= store_reg ? RESP : DRAIN;
        end
        DRAIN: begin
          ram_rw_en <= 1'b0;
          ram_wr    <= 1'b0;
          state_reg <= RESP;
        end
        RESP: begin
          ram_rw_en   <= 1'b0;
          ram_wr      <= 1'b0;
          out_valid   <= 1'b1;
          rd_data_o   <= res_data;
          rd_addr_o   <= rd_addr_reg;
          rd_enable_o <= res_en;
`ifdef MEM_MISALIGN_TRAP_EN
          misalign_o  <= mis_reg;
`endif
          in_ready    <= 1'b1;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with a byte-wide registered-read RAM model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  mem_op = 4'd0;
  logic [31:0] alu_res = 32'd0;
  logic [31:0] st_data = 32'd0;
  logic [4:0]  rd_addr = 5'd0;
  logic        rd_enable = 1'b0;
  logic [31:0] ram_addr;
  logic        ram_rw_en;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = 8'h00;
  logic        out_valid;
  logic [31:0] rd_data_o;
  logic [4:0]  rd_addr_o;
  logic        rd_enable_o;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [0:1023];
  logic [31:0] wr_addr [0:7];
  logic [7:0]  wr_byte [0:7];
  int          wr_cyc  [0:7];
  int          nwr;
  int          nrw;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mem_op(mem_op), .alu_res(alu_res), .st_data(st_data),
    .rd_addr(rd_addr), .rd_enable(rd_enable),
    .ram_addr(ram_addr), .ram_rw_en(ram_rw_en), .ram_wr(ram_wr),
    .ram_dout(ram_dout), .ram_din(ram_din),
    .out_valid(out_valid), .rd_data_o(rd_data_o), .rd_addr_o(rd_addr_o),
    .rd_enable_o(rd_enable_o)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign_o(misalign_o)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_rw_en) begin
      if (ram_wr) mem[ram_addr[9:0]] <= ram_dout;
      else        ram_din <= mem[ram_addr[9:0]];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Presents one transaction, then waits up to 20 cycles for out_valid; lat = -1 on timeout.
  task automatic do_op(input logic [3:0] op, input logic [31:0] alu, input logic [31:0] st,
                       input logic [4:0] rd, input logic en, output int lat);
    nwr = 0;
    nrw = 0;
    lat = -1;
    @(negedge clk);
    mem_op = op; alu_res = alu; st_data = st; rd_addr = rd; rd_enable = en; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(negedge clk);
      if (ram_rw_en) begin
        nrw++;
        if (ram_wr && nwr < 8) begin
          wr_addr[nwr] = ram_addr; wr_byte[nwr] = ram_dout; wr_cyc[nwr] = c; nwr++;
        end
      end
      if (out_valid) lat = c;
    end
    $display("txn op=%0d addr=%h st=%h -> lat=%0d data=%h rd=%0d en=%0b",
             op, alu, st, lat, rd_data_o, rd_addr_o, rd_enable_o);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (ram_rw_en !== 1'b0) begin failures++; $display("FAIL reset_rw_en: got %b expected 0", ram_rw_en); end
    checks++; if ({rd_data_o, rd_addr_o, rd_enable_o} !== 38'd0) begin failures++; $display("FAIL reset_results: got %h expected 0", {rd_data_o, rd_addr_o, rd_enable_o}); end
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({in_ready, out_valid, ram_rw_en} !== 3'b100) begin failures++; $display("FAIL idle_after_reset: got %b expected 100", {in_ready, out_valid, ram_rw_en}); end
  endtask

  task automatic test_store_word();
    int lat;
    logic [7:0] exp_b [0:3];
    exp_b[0] = 8'hD4; exp_b[1] = 8'hC3; exp_b[2] = 8'hB2; exp_b[3] = 8'hA1;
    do_op(4'd8, 32'h100, 32'hA1B2C3D4, 5'd9, 1'b1, lat);
    checks++; if (lat != 5) begin failures++; $display("FAIL sw_latency: got %0d expected 5", lat); end
    checks++; if (nwr != 4) begin failures++; $display("FAIL sw_write_count: got %0d expected 4", nwr); end
    for (int i = 0; i < 4 && i < nwr; i++) begin
      checks++;
      if (wr_addr[i] !== 32'h100 + i || wr_byte[i] !== exp_b[i] || wr_cyc[i] != i + 1) begin
        failures++;
        $display("FAIL sw_byte%0d: got addr=%h data=%h cyc=%0d expected addr=%h data=%h cyc=%0d",
                 i, wr_addr[i], wr_byte[i], wr_cyc[i], 32'h100 + i, exp_b[i], i + 1);
      end
    end
    checks++; if (rd_enable_o !== 1'b0 || rd_data_o !== 32'd0) begin failures++; $display("FAIL sw_result: got en=%b data=%h expected en=0 data=0", rd_enable_o, rd_data_o); end
  endtask

  task automatic test_loads();
    int lat;
    logic [31:0] held;
    do_op(4'd3, 32'h100, 32'd0, 5'd3, 1'b1, lat);
    checks++; if (lat != 6 || rd_data_o !== 32'hA1B2C3D4) begin failures++; $display("FAIL lw: got lat=%0d data=%h expected lat=6 data=a1b2c3d4", lat, rd_data_o); end
    checks++; if (rd_addr_o !== 5'd3 || rd_enable_o !== 1'b1) begin failures++; $display("FAIL lw_dest: got rd=%0d en=%b expected rd=3 en=1", rd_addr_o, rd_enable_o); end
    checks++; if (nrw != 4) begin failures++; $display("FAIL lw_strobes: got %0d expected 4", nrw); end
    held = rd_data_o;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || rd_data_o !== held || in_ready !== 1'b1) begin failures++; $display("FAIL lw_hold: got v=%b data=%h rdy=%b expected v=0 data=a1b2c3d4 rdy=1", out_valid, rd_data_o, in_ready); end
    do_op(4'd1, 32'h103, 32'd0, 5'd4, 1'b1, lat);
    checks++; if (lat != 3 || rd_data_o !== 32'hFFFFFFA1) begin failures++; $display("FAIL lb: got lat=%0d data=%h expected lat=3 data=ffffffa1", lat, rd_data_o); end
    do_op(4'd4, 32'h103, 32'd0, 5'd4, 1'b1, lat);
    checks++; if (lat != 3 || rd_data_o !== 32'h000000A1) begin failures++; $display("FAIL lbu: got lat=%0d data=%h expected lat=3 data=000000a1", lat, rd_data_o); end
    do_op(4'd2, 32'h102, 32'd0, 5'd6, 1'b1, lat);
    checks++; if (lat != 4 || rd_data_o !== 32'hFFFFA1B2) begin failures++; $display("FAIL lh: got lat=%0d data=%h expected lat=4 data=ffffa1b2", lat, rd_data_o); end
    do_op(4'd5, 32'h102, 32'd0, 5'd6, 1'b0, lat);
    checks++; if (lat != 4 || rd_data_o !== 32'h0000A1B2 || rd_enable_o !== 1'b0) begin failures++; $display("FAIL lhu: got lat=%0d data=%h en=%b expected lat=4 data=0000a1b2 en=0", lat, rd_data_o, rd_enable_o); end
  endtask

  task automatic test_none();
    int lat;
    do_op(4'd0, 32'h1234, 32'hFFFF, 5'd5, 1'b1, lat);
    checks++; if (lat != 1 || rd_data_o !== 32'h1234 || rd_addr_o !== 5'd5 || rd_enable_o !== 1'b1) begin failures++; $display("FAIL none: got lat=%0d data=%h rd=%0d en=%b expected lat=1 data=1234 rd=5 en=1", lat, rd_data_o, rd_addr_o, rd_enable_o); end
    checks++; if (nrw != 0) begin failures++; $display("FAIL none_no_ram: got %0d expected 0", nrw); end
    do_op(4'd12, 32'hCAFE0001, 32'd0, 5'd17, 1'b1, lat);
    checks++; if (lat != 1 || rd_data_o !== 32'hCAFE0001 || rd_addr_o !== 5'd17 || nrw != 0) begin failures++; $display("FAIL op12_as_none: got lat=%0d data=%h rd=%0d strobes=%0d expected lat=1 data=cafe0001 rd=17 strobes=0", lat, rd_data_o, rd_addr_o, nrw); end
  endtask

  task automatic test_small_stores();
    int lat;
    do_op(4'd6, 32'h200, 32'h12345655, 5'd1, 1'b1, lat);
    checks++; if (lat != 2 || nwr != 1 || wr_byte[0] !== 8'h55 || rd_enable_o !== 1'b0) begin failures++; $display("FAIL sb: got lat=%0d writes=%0d byte=%h en=%b expected lat=2 writes=1 byte=55 en=0", lat, nwr, wr_byte[0], rd_enable_o); end
    do_op(4'd7, 32'h202, 32'h0000BEEF, 5'd1, 1'b1, lat);
    checks++; if (lat != 3 || nwr != 2 || wr_byte[0] !== 8'hEF || wr_byte[1] !== 8'hBE) begin failures++; $display("FAIL sh: got lat=%0d writes=%0d bytes=%h%h expected lat=3 writes=2 bytes=beef", lat, nwr, wr_byte[1], wr_byte[0]); end
    do_op(4'd2, 32'h202, 32'd0, 5'd2, 1'b1, lat);
    checks++; if (rd_data_o !== 32'hFFFFBEEF) begin failures++; $display("FAIL lh_after_sh: got %h expected ffffbeef", rd_data_o); end
    do_op(4'd3, 32'h200, 32'd0, 5'd2, 1'b1, lat);
    checks++; if (rd_data_o !== 32'hBEEF0055) begin failures++; $display("FAIL lw_mixed: got %h expected beef0055", rd_data_o); end
  endtask

  task automatic test_busy_ignore();
    int seen;
    @(negedge clk);
    mem_op = 4'd6; alu_res = 32'h210; st_data = 32'h77; rd_addr = 5'd2; rd_enable = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    mem_op = 4'd0; alu_res = 32'hDEAD; rd_addr = 5'd7;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL busy_in_ready: got %b expected 0", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    $display("txn busy-ignore: out_valid pulses=%0d last data=%h", seen, rd_data_o);
    checks++; if (seen != 1 || rd_data_o !== 32'd0) begin failures++; $display("FAIL busy_ignored: got pulses=%0d data=%h expected pulses=1 data=0", seen, rd_data_o); end
    checks++; if (mem[10'h210] !== 8'h77) begin failures++; $display("FAIL busy_sb_mem: got %h expected 77", mem[10'h210]); end
  endtask

  task automatic test_reset_mid();
    int seen;
    int lat;
    @(negedge clk);
    mem_op = 4'd8; alu_res = 32'h300; st_data = 32'h01020304; rd_addr = 5'd1; rd_enable = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ram_rw_en !== 1'b1 || ram_addr !== 32'h301) begin failures++; $display("FAIL mid_issue: got en=%b addr=%h expected en=1 addr=301", ram_rw_en, ram_addr); end
    rst = 1'b0;
    #1;
    checks++; if (ram_rw_en !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_async: got en=%b rdy=%b expected en=0 rdy=1", ram_rw_en, in_ready); end
    @(negedge clk); rst = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid || ram_rw_en) seen++;
    end
    $display("txn reset-abort: stray activity cycles=%0d", seen);
    checks++; if (seen != 0) begin failures++; $display("FAIL mid_no_response: got %0d expected 0", seen); end
    do_op(4'd1, 32'h100, 32'd0, 5'd8, 1'b1, lat);
    checks++; if (lat != 3 || rd_data_o !== 32'hFFFFFFD4 || rd_addr_o !== 5'd8) begin failures++; $display("FAIL lb_after_reset: got lat=%0d data=%h rd=%0d expected lat=3 data=ffffffd4 rd=8", lat, rd_data_o, rd_addr_o); end
  endtask

`ifdef MEM_MISALIGN_TRAP_EN
  task automatic test_misalign();
    int lat;
    do_op(4'd3, 32'h101, 32'd0, 5'd4, 1'b1, lat);
    checks++; if (lat != 1 || misalign_o !== 1'b1 || rd_enable_o !== 1'b0 || rd_data_o !== 32'd0 || nrw != 0) begin failures++; $display("FAIL lw_misaligned: got lat=%0d mis=%b en=%b data=%h strobes=%0d expected lat=1 mis=1 en=0 data=0 strobes=0", lat, misalign_o, rd_enable_o, rd_data_o, nrw); end
    @(negedge clk);
    checks++; if (misalign_o !== 1'b0) begin failures++; $display("FAIL misalign_pulse: got %b expected 0", misalign_o); end
    do_op(4'd2, 32'h102, 32'd0, 5'd4, 1'b1, lat);
    checks++; if (lat != 4 || misalign_o !== 1'b0 || rd_data_o !== 32'hFFFFA1B2) begin failures++; $display("FAIL lh_aligned_trap_build: got lat=%0d mis=%b data=%h expected lat=4 mis=0 data=ffffa1b2", lat, misalign_o, rd_data_o); end
  endtask
`else
  task automatic test_addr_wrap();
    int lat;
    do_op(4'd7, 32'hFFFFFFFF, 32'h00009A8B, 5'd1, 1'b0, lat);
    checks++; if (lat != 3 || nwr != 2 || wr_addr[0] !== 32'hFFFFFFFF || wr_addr[1] !== 32'h00000000) begin failures++; $display("FAIL sh_wrap: got lat=%0d writes=%0d a0=%h a1=%h expected lat=3 writes=2 a0=ffffffff a1=00000000", lat, nwr, wr_addr[0], wr_addr[1]); end
    do_op(4'd5, 32'hFFFFFFFF, 32'd0, 5'd1, 1'b1, lat);
    checks++; if (lat != 4 || rd_data_o !== 32'h00009A8B) begin failures++; $display("FAIL lhu_wrap: got lat=%0d data=%h expected lat=4 data=00009a8b", lat, rd_data_o); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    test_reset();
    test_store_word();
    test_loads();
    test_none();
    test_small_stores();
    test_busy_ignore();
    test_reset_mid();
`ifdef MEM_MISALIGN_TRAP_EN
    test_misalign();
`else
    test_addr_wrap();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
